// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding, controller states and latency helper for alu_share_ctrl
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_ADDI = 5'd9;
    localparam logic [4:0] OP_SLTI = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_DIV  = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: first valid requester at or above ptr wins
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [IDW-1:0] cand [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_cand
        assign cand[i] = IDW'((int'(ptr) + i) % NREQ);
    end

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid[cand[i]]) begin
                found          = 1'b1;
                grant[cand[i]] = 1'b1;
                idx            = cand[i];
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between NREQ requesters; option ALU_SHARE_FAST_ISSUE_EN
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int  NREQ       = 2,
    parameter int  TAG_W      = 4,
    parameter int  MULDIV_LAT = 4,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*5-1:0]     req_op,
    input  logic [NREQ*32-1:0]    req_rs1,
    input  logic [NREQ*32-1:0]    req_rs2,
    input  logic [NREQ*12-1:0]    req_imm,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic [4:0]            alu_op,
    output logic [31:0]           alu_rs1,
    output logic [31:0]           alu_rs2,
    output logic [11:0]           alu_imm,
    output logic                  alu_en,
    input  logic [31:0]           alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  busy
);

    localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    state_t         state, state_d;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [NREQ-1:0] grant;
    logic           grant_found;
    logic           issue;
    logic [4:0]     sel_op;
    logic           div_zero;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    assign sel_op   = req_op[grant_idx*5 +: 5];
    assign div_zero = (alu_op == OP_DIV) && (alu_imm == 12'd0);

    // issue marks the request handshake; it can only happen where arbitration is open
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    issue   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
`ifdef ALU_SHARE_FAST_ISSUE_EN
                    issue   = grant_found;
                    state_d = grant_found ? EXEC : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = issue ? grant : '0;
    assign alu_en    = (state == EXEC);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            alu_op   <= '0;
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            alu_imm  <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_tag  <= '0;
        end else begin
            state <= state_d;
            if (issue) begin
                alu_op  <= sel_op;
                alu_rs1 <= req_rs1[grant_idx*32 +: 32];
                alu_rs2 <= req_rs2[grant_idx*32 +: 32];
                alu_imm <= req_imm[grant_idx*12 +: 12];
                rsp_tag <= req_tag[grant_idx*TAG_W +: TAG_W];
                rsp_id  <= grant_idx;
                cnt     <= is_multicycle(sel_op) ? CW'(MULDIV_LAT - 1) : '0;
                rr_ptr  <= IDW'((int'(grant_idx) + 1) % NREQ);
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // the ALU result is not trusted for division by a zero immediate
            if (state == EXEC && cnt == '0) begin
                rsp_data <= div_zero ? 32'hFFFF_FFFF : alu_out;
            end
        end
    end

endmodule
